// File: rtl/pipe_pkg.sv
// Shared hazard-control types: FSM state encoding, MD_LAT bounds,
// and the packed control-output bundle with its RUN default.
package pipe_pkg;

  localparam int MD_LAT_MIN = 2;
  localparam int MD_LAT_MAX = 16;

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MD_WAIT = 1'b1;

  typedef enum logic {
    RUN     = ST_RUN,
    MD_WAIT = ST_MD_WAIT
  } hz_state_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_bubble;
    logic md_done;
  } hz_ctrl_t;

  function automatic hz_ctrl_t ctrl_default();
    hz_ctrl_t c;
    c              = '0;
    c.pc_we        = 1'b1;
    c.ifid_we      = 1'b1;
    c.idex_we      = 1'b1;
    return c;
  endfunction

  function automatic hz_ctrl_t ctrl_md_stall();
    hz_ctrl_t c;
    c              = '0;
    c.exmem_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit saturating event counter with synchronous clear.
// Ports: clk, rst (async low), inc_i, clear_i, cnt_o.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        clear_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (inc_i && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use bubble, taken-branch flush,
// multi-cycle EX stall, plus saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memR,
  input  logic        ex_muldiv,
  input  logic        ex_br_taken,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_flush,
  output logic        exmem_bubble,
  output logic        md_done,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  // First EX cycle is spent in RUN, last one reports md_done.
  localparam logic [3:0] CNT_INIT = 4'(MD_LAT - 2);

  hz_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  hz_ctrl_t   ctrl;
  logic       lu;
  logic       hit1;
  logic       hit2;

  assign hit1 = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit2 = id_use_rs2 && (id_rs2 == ex_rd);
  assign lu   = ex_memR && (ex_rd != 5'd0) && (hit1 || hit2);

  always_comb begin
    ctrl    = ctrl_default();
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (ex_br_taken) begin
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
        end else if (ex_muldiv) begin
          ctrl    = ctrl_md_stall();
          cnt_d   = CNT_INIT;
          state_d = MD_WAIT;
        end else if (lu) begin
          ctrl.pc_we      = 1'b0;
          ctrl.ifid_we    = 1'b0;
          ctrl.idex_flush = 1'b1;
        end
      end
      MD_WAIT: begin
        if (cnt_q != 4'd0) begin
          ctrl  = ctrl_md_stall();
          cnt_d = cnt_q - 4'd1;
        end else begin
          ctrl.md_done = 1'b1;
          state_d      = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // Outputs stay quiet while reset is held, whatever the inputs do.
    if (!rst)
      ctrl = ctrl_default();
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_we        = ctrl.pc_we;
  assign ifid_we      = ctrl.ifid_we;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_we      = ctrl.idex_we;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign md_done      = ctrl.md_done;

  sat_cnt16 u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (~ctrl.pc_we),
    .clear_i (1'b0),
    .cnt_o   (stall_cnt)
  );

  sat_cnt16 u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (ctrl.ifid_flush),
    .clear_i (1'b0),
    .cnt_o   (flush_cnt)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 4: total EX-stage occupancy in cycles of a multi-cycle (mul/div) op; legal range 2..16.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads rs1 / rs2.
REQ-006 ex_rd  in  5  destination register of the instruction in EX.
REQ-007 ex_memR  in  1  the EX instruction is a load.
REQ-008 ex_muldiv  in  1  the EX instruction is a multi-cycle op.
REQ-009 ex_br_taken  in  1  a branch/jump resolved taken in EX this cycle.
REQ-010 pc_we  out  1  PC write enable.
REQ-011 ifid_we  out  1  IF/ID register write enable.
REQ-012 ifid_flush  out  1  IF/ID loads a NOP.
REQ-013 idex_we  out  1  ID/EX register write enable.
REQ-014 idex_flush  out  1  ID/EX loads all-zero control (bubble).
REQ-015 exmem_bubble  out  1  EX/MEM loads all-zero control.
REQ-016 md_done  out  1  one-cycle pulse on the last EX cycle of a multi-cycle op.
REQ-017 stall_cnt  out  16  saturating count of cycles with pc_we=0.
REQ-018 flush_cnt  out  16  saturating count of taken-branch flushes.

Function
REQ-019 States RUN and MD_WAIT; 4-bit down-counter cnt.
REQ-020 Default (no event): pc_we=ifid_we=idex_we=1; flush/bubble/md_done outputs 0.
REQ-021 Load-use hazard lu = ex_memR & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)), combinational.
REQ-022 RUN priority: ex_br_taken > ex_muldiv > lu.
REQ-023 RUN & ex_br_taken: pc_we=1, ifid_flush=1, idex_flush=1; flush_cnt increments; next RUN.
REQ-024 RUN & ex_muldiv (no branch): pc_we=ifid_we=idex_we=0, exmem_bubble=1; cnt<=MD_LAT-2; next MD_WAIT.
REQ-025 RUN & lu (no branch/muldiv): pc_we=ifid_we=0, idex_flush=1, idex_we=1; next RUN (exactly one bubble).
REQ-026 MD_WAIT & cnt!=0: hold outputs as REQ-024; cnt decrements.
REQ-027 MD_WAIT & cnt==0: default outputs with md_done=1; next RUN; total EX occupancy exactly MD_LAT cycles.
REQ-028 Inputs ignored in MD_WAIT except through REQ-027's default outputs; lu and ex_br_taken not evaluated until RUN.
REQ-029 stall_cnt increments each cycle pc_we=0; both counters saturate at 16'hFFFF, no wrap.
REQ-030 All control outputs combinational from state, cnt and inputs; counters registered.

Reset
REQ-031 rst low: state=RUN, cnt=0, stall_cnt=0, flush_cnt=0 immediately, regardless of clk.
REQ-032 Reset during MD_WAIT abandons the op; no md_done pulse.
REQ-033 During reset, control outputs show RUN default values (REQ-020).

Structure
REQ-034 State encoding localparams and MD_LAT bounds in shared package pipe_pkg.
REQ-035 Saturating counters built from one sub-module sat_cnt16 (inc, clear), instantiated twice.

Verification
REQ-036 ex_memR=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_we=0, ifid_we=0, idex_flush=1; stall_cnt=1.
REQ-037 Same as REQ-036 but ex_rd=0 -> no stall, outputs default.
REQ-038 ex_muldiv=1, MD_LAT=4 -> pc_we=0 for 3 cycles, md_done=1 on 4th, then RUN; stall_cnt=3.
REQ-039 ex_br_taken=1 with lu true the same cycle -> ifid_flush=idex_flush=1, pc_we=1; flush_cnt=1, stall_cnt unchanged.
REQ-040 rst low mid-MD_WAIT (cnt=1) -> state RUN, counters 0, md_done never asserted.
REQ-041 Force flush_cnt to 16'hFFFF, one more taken branch -> stays 16'hFFFF.
